// File: rtl/multicycle_cpu.sv
// multicycle_cpu: multi-cycle MIPS-subset core with one shared memory port.
// Each instruction walks FETCH -> DECODE -> EXEC [-> MEM] [-> WB]; memory may
// stretch FETCH and MEM with wait states through the req/ready handshake.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   mem_req/mem_we    access request / write strobe (sw only)
//   mem_addr          word-aligned byte address (low ADDR_W bits)
//   mem_wdata         store data
//   mem_rdata         read data, sampled when mem_req && mem_ready
//   mem_ready         completes the access on the current edge
//   halted            sticky flag, set by an illegal opcode/funct
//   pc_dbg            current program counter
module multicycle_cpu #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          ADDR_W   = 32,
    parameter int          NREG_AW  = 5
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              halted,
    output logic [31:0]       pc_dbg
);
    localparam int NREG = 1 << NREG_AW;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    state_t state, state_nx;

    logic [31:0] pc, ir, a, b, alu_out, mdr;
    logic [31:0] regs [NREG];

    // instruction fields
    logic [5:0]         op, funct;
    logic [4:0]         shamt;
    logic [15:0]        imm;
    logic [25:0]        target;
    logic [NREG_AW-1:0] rs_idx, rt_idx, rd_idx, wb_idx;
    logic [31:0]        simm;

    assign op     = ir[31:26];
    assign funct  = ir[5:0];
    assign shamt  = ir[10:6];
    assign imm    = ir[15:0];
    assign target = ir[25:0];
    assign rs_idx = ir[21 +: NREG_AW];
    assign rt_idx = ir[16 +: NREG_AW];
    assign rd_idx = ir[11 +: NREG_AW];
    assign simm   = {{16{imm[15]}}, imm};

    // instruction class decode
    logic is_r, is_addu, is_subu, is_and, is_or, is_slt, is_sll, is_jr;
    logic is_addiu, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;
    logic legal, is_ctrl;

    assign is_r     = (op == 6'h00);
    assign is_addu  = is_r && (funct == 6'h21);
    assign is_subu  = is_r && (funct == 6'h23);
    assign is_and   = is_r && (funct == 6'h24);
    assign is_or    = is_r && (funct == 6'h25);
    assign is_slt   = is_r && (funct == 6'h2A);
    assign is_sll   = is_r && (funct == 6'h00);
    assign is_jr    = is_r && (funct == 6'h08);
    assign is_addiu = (op == 6'h09);
    assign is_ori   = (op == 6'h0D);
    assign is_lui   = (op == 6'h0F);
    assign is_lw    = (op == 6'h23);
    assign is_sw    = (op == 6'h2B);
    assign is_beq   = (op == 6'h04);
    assign is_j     = (op == 6'h02);
    assign is_jal   = (op == 6'h03);

    assign legal = is_addu | is_subu | is_and | is_or | is_slt | is_sll | is_jr |
                   is_addiu | is_ori | is_lui | is_lw | is_sw | is_beq | is_j | is_jal;
    assign is_ctrl = is_beq | is_j | is_jal | is_jr;

    // R-type writes rd, I-type (incl. lw) writes rt
    assign wb_idx = is_r ? rd_idx : rt_idx;

    // shared ALU
    logic [31:0] alu_res;
    always_comb begin
        alu_res = '0;
        if (is_addu)              alu_res = a + b;
        else if (is_subu)         alu_res = a - b;
        else if (is_and)          alu_res = a & b;
        else if (is_or)           alu_res = a | b;
        else if (is_slt)          alu_res = {31'b0, $signed(a) < $signed(b)};
        else if (is_sll)          alu_res = b << shamt;
        else if (is_ori)          alu_res = a | {16'b0, imm};
        else if (is_lui)          alu_res = {imm, 16'b0};
        else if (is_addiu | is_lw | is_sw) alu_res = a + simm;
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // next state and memory request; request outputs are pure functions of
    // state and registers, so they hold steady across wait cycles and drop
    // the instant reset forces IDLE
    logic [31:0] req_addr;
    always_comb begin
        state_nx  = state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        req_addr  = '0;
        mem_wdata = '0;
        case (state)
            S_IDLE:   state_nx = S_FETCH;
            S_FETCH: begin
                mem_req  = 1'b1;
                req_addr = {pc[31:2], 2'b00};
                if (mem_ready) state_nx = S_DECODE;
            end
            S_DECODE: state_nx = legal ? S_EXEC : S_HALT;
            S_EXEC: begin
                if (is_ctrl)             state_nx = S_FETCH;
                else if (is_lw | is_sw)  state_nx = S_MEM;
                else                     state_nx = S_WB;
            end
            S_MEM: begin
                mem_req   = 1'b1;
                mem_we    = is_sw;
                req_addr  = {alu_out[31:2], 2'b00};
                mem_wdata = b;
                if (mem_ready) state_nx = is_sw ? S_FETCH : S_WB;
            end
            S_WB:     state_nx = S_FETCH;
            S_HALT:   state_nx = S_HALT;
            default:  state_nx = S_IDLE;
        endcase
    end

    assign mem_addr = req_addr[ADDR_W-1:0];
    assign halted   = (state == S_HALT);
    assign pc_dbg   = pc;

    // datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc      <= RESET_PC;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            alu_out <= '0;
            mdr     <= '0;
        end else begin
            case (state)
                S_FETCH: if (mem_ready) begin
                    ir <= mem_rdata;
                    pc <= pc + 32'd4;
                end
                S_DECODE: begin
                    a <= (rs_idx == '0) ? 32'd0 : regs[rs_idx];
                    b <= (rt_idx == '0) ? 32'd0 : regs[rt_idx];
                end
                S_EXEC: begin
                    alu_out <= alu_res;
                    // pc already points past this instruction
                    if (is_beq && (a == b)) pc <= pc + (simm << 2);
                    if (is_j | is_jal)      pc <= {pc[31:28], target, 2'b00};
                    if (is_jr)              pc <= a;
                end
                S_MEM: if (mem_ready && !is_sw) mdr <= mem_rdata;
                default: ;
            endcase
        end
    end

    // register file; entry 0 is never written so it always reads 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            if (state == S_EXEC && is_jal)
                regs[NREG-1] <= pc;
            if (state == S_WB && wb_idx != '0)
                regs[wb_idx] <= is_lw ? mdr : alu_out;
        end
    end

endmodule

// File: tb/tb_multicycle_cpu.sv
module tb_multicycle_cpu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req, mem_we, mem_ready, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_dbg;

    multicycle_cpu dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .halted(halted), .pc_dbg(pc_dbg)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // memory model: program words written only by the tasks; the last store is
    // kept aside and overrides reads of its address
    logic [31:0] mem [4096];
    int          wait_n = 0;
    logic        hold = 1'b0;
    int          wcnt = 0;
    int          cyc = 0;
    int          wr_cnt = 0;
    int          wr_cyc = 0;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    int          unstable_cnt = 0;
    logic        pv = 1'b0;
    logic [31:0] p_addr = '0, p_wdata = '0;
    logic        p_we = 1'b0;
    logic [31:0] rd_log [$];

    assign mem_ready = mem_req && !hold && (wcnt >= wait_n);
    assign mem_rdata = (wr_cnt != 0 && mem_addr == wr_addr) ? wr_data : mem[mem_addr[13:2]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            wcnt <= 0;
            pv   <= 1'b0;
        end else begin
            if (!mem_req || mem_ready) wcnt <= 0;
            else                       wcnt <= wcnt + 1;
            if (mem_req && mem_ready) begin
                if (mem_we) begin
                    wr_cnt  <= wr_cnt + 1;
                    wr_addr <= mem_addr;
                    wr_data <= mem_wdata;
                    wr_cyc  <= cyc + 1;
                end else begin
                    rd_log.push_back(mem_addr);
                end
            end
            if (pv && (!mem_req || mem_addr != p_addr || mem_we != p_we || mem_wdata != p_wdata))
                unstable_cnt <= unstable_cnt + 1;
            pv      <= mem_req && !mem_ready;
            p_addr  <= mem_addr;
            p_we    <= mem_we;
            p_wdata <= mem_wdata;
        end
    end

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int sh, input int fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction
    function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction
    function automatic logic [31:0] enc_j(input int op, input logic [31:0] addr);
        return {6'(op), addr[27:2]};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 4096; i++) mem[i] = 32'hFC00_0000;
    endtask
    task automatic load(input logic [31:0] addr, input logic [31:0] w);
        mem[addr[13:2]] = w;
    endtask
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask
    // reset, then release on a falling edge; base = cycle stamp at release
    task automatic start_prog(output int base);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        base = cyc;
    endtask
    task automatic wait_halt(input int max, output int e);
        e = 0;
        while (!halted && e < max) begin
            @(negedge clk);
            e++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(2);
        n_chk++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
        n_chk++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we got %b exp 0", mem_we); end
        n_chk++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr); end
        n_chk++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_wdata got %h exp 0", mem_wdata); end
        n_chk++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b exp 0", halted); end
        n_chk++; if (pc_dbg !== 32'h3000) begin n_fail++; $display("FAIL reset_pc got %h exp 3000", pc_dbg); end
        rst = 1'b0;
        step(1);
        n_chk++; if (mem_req !== 1'b1 || mem_addr !== 32'h3000) begin n_fail++; $display("FAIL first_fetch got req=%b addr=%h exp req=1 addr=3000", mem_req, mem_addr); end
    endtask

    task automatic test_alu();
        int base, e;
        logic [31:0] exp_r [13];
        int          idx   [13];
        clear_mem();
        wait_n = 0;
        load(32'h3000, enc_i(8'h0D, 0, 1, 16'h1234));   // ori  $1,$0,0x1234
        load(32'h3004, enc_i(8'h0F, 0, 2, 16'h8000));   // lui  $2,0x8000
        load(32'h3008, enc_r(1, 2, 3, 0, 8'h21));       // addu $3,$1,$2
        load(32'h300C, enc_r(2, 1, 4, 0, 8'h2A));       // slt  $4,$2,$1
        load(32'h3010, enc_r(2, 1, 6, 0, 8'h23));       // subu $6,$2,$1
        load(32'h3014, enc_r(3, 1, 7, 0, 8'h24));       // and  $7,$3,$1
        load(32'h3018, enc_r(2, 1, 8, 0, 8'h25));       // or   $8,$2,$1
        load(32'h301C, enc_r(0, 1, 9, 4, 8'h00));       // sll  $9,$1,4
        load(32'h3020, enc_i(8'h09, 0, 10, 16'hFFFF));  // addiu $10,$0,-1
        load(32'h3024, enc_r(1, 2, 11, 0, 8'h2A));      // slt  $11,$1,$2
        load(32'h3028, enc_i(8'h09, 1, 12, 16'hFFCC));  // addiu $12,$1,-0x34
        load(32'h302C, 32'h0000_0000);                  // nop
        load(32'h3030, enc_i(8'h0D, 0, 0, 16'h0005));   // ori  $0,$0,5
        start_prog(base);
        step(13);
        n_chk++; if (pc_dbg !== 32'h300C) begin n_fail++; $display("FAIL alu_pc_after_12 got %h exp 300c", pc_dbg); end
        wait_halt(200, e);
        n_chk++; if (13 + e !== 55) begin n_fail++; $display("FAIL alu_cycles got %0d exp 55", 13 + e); end
        idx = '{3, 4, 6, 7, 8, 9, 10, 11, 12, 0, 1, 2, 5};
        exp_r = '{32'h8000_1234, 32'h1, 32'h7FFF_EDCC, 32'h1234, 32'h8000_1234, 32'h1_2340,
                  32'hFFFF_FFFF, 32'h0, 32'h1200, 32'h0, 32'h1234, 32'h8000_0000, 32'h0};
        for (int i = 0; i < 13; i++) begin
            n_chk++;
            if (dut.regs[idx[i]] !== exp_r[i]) begin
                n_fail++; $display("FAIL alu_reg%0d got %h exp %h", idx[i], dut.regs[idx[i]], exp_r[i]);
            end
        end
    endtask

    task automatic test_mem_wait();
        int base, e, w0, u0;
        clear_mem();
        wait_n = 2;
        load(32'h3000, enc_i(8'h0D, 0, 1, 16'h1234));
        load(32'h3004, enc_i(8'h0F, 0, 2, 16'h8000));
        load(32'h3008, enc_r(1, 2, 3, 0, 8'h21));
        load(32'h300C, enc_i(8'h2B, 0, 3, 4));          // sw $3,4($0)
        load(32'h3010, enc_i(8'h23, 0, 5, 4));          // lw $5,4($0)
        load(32'h3014, enc_i(8'h23, 0, 13, 7));         // lw $13,7($0), unaligned
        w0 = wr_cnt;
        u0 = unstable_cnt;
        start_prog(base);
        step(25);
        n_chk++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h4 || mem_wdata !== 32'h8000_1234) begin
            n_fail++; $display("FAIL sw_wait_req got req=%b we=%b addr=%h wd=%h exp 1 1 4 80001234", mem_req, mem_we, mem_addr, mem_wdata);
        end
        wait_halt(200, e);
        n_chk++; if (wr_cnt - w0 !== 1) begin n_fail++; $display("FAIL sw_count got %0d exp 1", wr_cnt - w0); end
        n_chk++; if (wr_addr !== 32'h4 || wr_data !== 32'h8000_1234) begin n_fail++; $display("FAIL sw_data got addr=%h data=%h exp 4 80001234", wr_addr, wr_data); end
        n_chk++; if (wr_cyc - base !== 27) begin n_fail++; $display("FAIL sw_edge got %0d exp 27", wr_cyc - base); end
        n_chk++; if (25 + e !== 49) begin n_fail++; $display("FAIL mem_cycles got %0d exp 49", 25 + e); end
        n_chk++; if (dut.regs[5] !== 32'h8000_1234) begin n_fail++; $display("FAIL lw_r5 got %h exp 80001234", dut.regs[5]); end
        n_chk++; if (dut.regs[13] !== 32'h8000_1234) begin n_fail++; $display("FAIL lw_unaligned got %h exp 80001234", dut.regs[13]); end
        n_chk++; if (unstable_cnt - u0 !== 0) begin n_fail++; $display("FAIL req_stable got %0d changes exp 0", unstable_cnt - u0); end
        wait_n = 0;
    endtask

    task automatic test_branch();
        int base, e, n0;
        logic [31:0] exp_f [7];
        clear_mem();
        load(32'h3000, enc_i(8'h04, 1, 1, 16'hFFFF));   // beq $1,$1,-1
        n0 = rd_log.size();
        start_prog(base);
        step(4);
        n_chk++; if (pc_dbg !== 32'h3000) begin n_fail++; $display("FAIL beq_loop_pc got %h exp 3000", pc_dbg); end
        n_chk++; if (mem_req !== 1'b1 || mem_addr !== 32'h3000) begin n_fail++; $display("FAIL beq_loop_fetch got req=%b addr=%h exp 1 3000", mem_req, mem_addr); end
        step(3);
        n_chk++; if (rd_log.size() - n0 !== 2 || rd_log[n0+1] !== 32'h3000) begin n_fail++; $display("FAIL beq_loop_count got %0d exp 2", rd_log.size() - n0); end

        clear_mem();
        load(32'h3000, enc_i(8'h0D, 0, 1, 1));          // ori $1,$0,1
        load(32'h3004, enc_i(8'h04, 1, 2, 2));          // beq $1,$2,+2 (not taken)
        load(32'h3008, enc_j(8'h03, 32'h3100));         // jal 0x3100
        load(32'h3100, enc_r(31, 0, 0, 0, 8'h08));      // jr $31
        load(32'h300C, enc_i(8'h04, 0, 0, 2));          // beq $0,$0,+2 -> 0x3018
        load(32'h3018, enc_j(8'h02, 32'h3020));         // j 0x3020
        start_prog(base);
        n0 = rd_log.size();
        wait_halt(200, e);
        n_chk++; if (e !== 22) begin n_fail++; $display("FAIL branch_cycles got %0d exp 22", e); end
        n_chk++; if (dut.regs[31] !== 32'h300C) begin n_fail++; $display("FAIL jal_ra got %h exp 300c", dut.regs[31]); end
        exp_f = '{32'h3000, 32'h3004, 32'h3008, 32'h3100, 32'h300C, 32'h3018, 32'h3020};
        n_chk++; if (rd_log.size() - n0 !== 7) begin n_fail++; $display("FAIL fetch_count got %0d exp 7", rd_log.size() - n0); end
        for (int i = 0; i < 7 && n0 + i < rd_log.size(); i++) begin
            n_chk++;
            if (rd_log[n0+i] !== exp_f[i]) begin n_fail++; $display("FAIL fetch_seq%0d got %h exp %h", i, rd_log[n0+i], exp_f[i]); end
        end
    endtask

    task automatic test_halt();
        int base;
        logic seen_req;
        clear_mem();                                    // 0x3000 holds opcode 0x3F
        start_prog(base);
        step(2);
        n_chk++; if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_early got %b exp 0", halted); end
        step(1);
        n_chk++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_at_decode got %b exp 1", halted); end
        seen_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            seen_req |= mem_req | ~halted;
        end
        n_chk++; if (seen_req !== 1'b0) begin n_fail++; $display("FAIL halt_sticky got %b exp 0", seen_req); end
        n_chk++; if (pc_dbg !== 32'h3004) begin n_fail++; $display("FAIL halt_pc got %h exp 3004", pc_dbg); end
        load(32'h3000, enc_r(0, 0, 0, 0, 8'h01));       // illegal funct
        start_prog(base);
        step(3);
        n_chk++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_funct got %b exp 1", halted); end
        #1 rst = 1'b1;
        #1;
        n_chk++; if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_clear got %b exp 0", halted); end
        rst = 1'b0;
    endtask

    task automatic test_reset_mid();
        int base, w0, n0;
        logic nz;
        clear_mem();
        load(32'h3000, enc_i(8'h0D, 0, 1, 16'h0055));   // ori $1,$0,0x55
        load(32'h3004, enc_i(8'h2B, 0, 1, 8));          // sw $1,8($0)
        start_prog(base);
        step(7);
        hold = 1'b1;
        step(1);
        n_chk++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h8 || mem_wdata !== 32'h55) begin
            n_fail++; $display("FAIL mid_sw_req got req=%b we=%b addr=%h wd=%h exp 1 1 8 55", mem_req, mem_we, mem_addr, mem_wdata);
        end
        w0 = wr_cnt;
        #2 rst = 1'b1;
        #1;
        n_chk++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            n_fail++; $display("FAIL mid_rst_drop got req=%b we=%b addr=%h wd=%h exp 0 0 0 0", mem_req, mem_we, mem_addr, mem_wdata);
        end
        step(2);
        n_chk++; if (wr_cnt !== w0) begin n_fail++; $display("FAIL mid_rst_nowrite got %0d exp %0d", wr_cnt, w0); end
        nz = 1'b0;
        for (int i = 0; i < 32; i++) nz |= (dut.regs[i] !== 32'h0);
        n_chk++; if (nz !== 1'b0) begin n_fail++; $display("FAIL mid_rst_regs got nonzero exp all 0"); end
        hold = 1'b0;
        n0 = rd_log.size();
        rst = 1'b0;
        step(2);
        n_chk++; if (rd_log.size() <= n0 || rd_log[n0] !== 32'h3000) begin n_fail++; $display("FAIL mid_rst_refetch got %0d fetches exp 3000", rd_log.size() - n0); end
    endtask

    initial begin
        clear_mem();
        test_reset();
        test_alu();
        test_mem_wait();
        test_branch();
        test_halt();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
